// File: rtl/obstacle_scheduler.sv
// Obstacle spawn sequencer: counts frame ticks per level, allocates the lowest free slot,
// then issues a spawn over valid/ready. Request held stable until accepted; flush/level loss drops it.
module obstacle_scheduler #(
    parameter int NUM_SLOTS = 4,
    parameter int INT_L0    = 60,
    parameter int INT_L1    = 40,
    parameter int INT_L2    = 25,
    localparam int SLOT_W   = $clog2(NUM_SLOTS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic [2:0]           level,
    input  logic                 playerDied,
    input  logic [NUM_SLOTS-1:0] slot_done,
    input  logic                 spawn_ready,
    output logic                 spawn_valid,
    output logic [SLOT_W-1:0]    spawn_slot,
    output logic [2:0]           spawn_lane,
    output logic [NUM_SLOTS-1:0] slot_busy,
    output logic [10:0]          obj_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_ALLOC = 2'd2,
        S_ISSUE = 2'd3
    } state_t;

    state_t               r_state;
    logic [7:0]           r_cnt;
    logic [7:0]           r_lfsr;
    logic [2:0]           r_prev_lvl;
    logic                 r_valid;
    logic [SLOT_W-1:0]    r_slot;
    logic [2:0]           r_lane;
    logic [NUM_SLOTS-1:0] r_busy;
    logic [10:0]          r_count;

    logic [2:0]           w_lvl;
    logic                 w_lvl_change;
    logic [7:0]           w_interval;
    logic                 w_cnt_last;
    logic                 w_free_found;
    logic [SLOT_W-1:0]    w_free_idx;
    logic                 w_hs;
    logic [NUM_SLOTS-1:0] w_alloc_onehot;
    logic [NUM_SLOTS-1:0] w_busy_next;
    logic                 w_lfsr_fb;

    // Anything other than a single set bit means "no play".
    assign w_lvl = (level == 3'b001 || level == 3'b010 || level == 3'b100) ? level : 3'b000;
    assign w_lvl_change = (w_lvl != 3'b000) && (r_prev_lvl != 3'b000) && (w_lvl != r_prev_lvl);

    always_comb begin
        w_interval = 8'd1;
        case (w_lvl)
            3'b001:  w_interval = 8'(INT_L0);
            3'b010:  w_interval = 8'(INT_L1);
            3'b100:  w_interval = 8'(INT_L2);
            default: w_interval = 8'd1;
        endcase
    end

    assign w_cnt_last = (r_cnt == w_interval - 8'd1);

    // Scan high to low so the lowest free index wins.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = SLOT_W'(i);
            end
        end
    end

    assign w_hs = (r_state == S_ISSUE) && r_valid && spawn_ready && !playerDied
                  && (w_lvl != 3'b000) && !w_lvl_change;
    assign w_alloc_onehot = w_hs ? (NUM_SLOTS'(1) << r_slot) : '0;
    assign w_busy_next    = (r_busy & ~slot_done) | w_alloc_onehot;
    assign w_lfsr_fb      = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_lfsr     <= 8'hA5;
            r_prev_lvl <= 3'b000;
            r_valid    <= 1'b0;
            r_slot     <= '0;
            r_lane     <= 3'd0;
            r_busy     <= '0;
            r_count    <= 11'd0;
        end else begin
            r_prev_lvl <= w_lvl;
            if (playerDied) begin
                r_busy  <= '0;
                r_count <= 11'd0;
                r_cnt   <= 8'd0;
                r_valid <= 1'b0;
                r_state <= S_IDLE;
            end else begin
                r_busy <= w_busy_next;
                if (w_lvl == 3'b000) begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_cnt   <= 8'd0;
                end else if (w_lvl_change) begin
                    r_state <= S_COUNT;
                    r_valid <= 1'b0;
                    r_cnt   <= 8'd0;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            r_state <= S_COUNT;
                            r_cnt   <= 8'd0;
                        end
                        S_COUNT: begin
                            if (frame_tick) begin
                                if (w_cnt_last) begin
                                    r_cnt   <= 8'd0;
                                    r_state <= S_ALLOC;
                                end else begin
                                    r_cnt <= r_cnt + 8'd1;
                                end
                            end
                        end
                        S_ALLOC: begin
                            // With every slot busy the spawn waits here rather than being lost.
                            if (w_free_found) begin
                                r_slot  <= w_free_idx;
                                r_lane  <= r_lfsr[2:0];
                                r_valid <= 1'b1;
                                r_state <= S_ISSUE;
                            end
                        end
                        S_ISSUE: begin
                            if (w_hs) begin
                                r_valid <= 1'b0;
                                if (r_count != 11'h7FF) begin
                                    r_count <= r_count + 11'd1;
                                end
                                r_lfsr  <= {r_lfsr[6:0], w_lfsr_fb};
                                r_state <= S_COUNT;
                            end
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign spawn_valid = r_valid;
    assign spawn_slot  = r_slot;
    assign spawn_lane  = r_lane;
    assign slot_busy   = r_busy;
    assign obj_count   = r_count;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler: per-row stimulus with hand-computed outputs,
// plus hand sequences for ready backpressure and the all-slots-busy stall.
module tb_obstacle_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic [2:0]  level;
    logic        playerDied;
    logic [3:0]  slot_done;
    logic        spawn_ready;
    logic        spawn_valid;
    logic [1:0]  spawn_slot;
    logic [2:0]  spawn_lane;
    logic [3:0]  slot_busy;
    logic [10:0] obj_count;

    int n_pass  = 0;
    int n_total = 0;

    obstacle_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .level       (level),
        .playerDied  (playerDied),
        .slot_done   (slot_done),
        .spawn_ready (spawn_ready),
        .spawn_valid (spawn_valid),
        .spawn_slot  (spawn_slot),
        .spawn_lane  (spawn_lane),
        .slot_busy   (slot_busy),
        .obj_count   (obj_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  lvl;
        logic        rdy;
        int          n;      // spaced frame ticks applied before the checked cycle
        logic        died;
        logic [3:0]  done;
        logic        ftk;
        logic        chk_sl; // compare slot/lane too
        logic        ev;
        logic [1:0]  es;
        logic [2:0]  el;
        logic [3:0]  eb;
        logic [10:0] ec;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [2:0] lvl, input logic rdy, input int n, input logic died,
                       input logic [3:0] done, input logic ftk, input logic chk_sl, input logic ev,
                       input logic [1:0] es, input logic [2:0] el, input logic [3:0] eb,
                       input logic [10:0] ec);
        vec_t v;
        v = '{lvl, rdy, n, died, done, ftk, chk_sl, ev, es, el, eb, ec};
        tbl.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_spaced(input int n);
        for (int t = 0; t < n; t++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            repeat (3) step();
        end
    endtask

    task automatic check(input string name, input logic ok, input string detail);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    task automatic apply(input int k);
        vec_t v;
        logic ok;
        v = tbl[k];
        level       = v.lvl;
        spawn_ready = v.rdy;
        tick_spaced(v.n);
        playerDied  = v.died;
        slot_done   = v.done;
        frame_tick  = v.ftk;
        step();
        playerDied  = 1'b0;
        slot_done   = 4'b0000;
        frame_tick  = 1'b0;
        ok = (spawn_valid === v.ev) && (slot_busy === v.eb) && (obj_count === v.ec);
        if (v.chk_sl) ok = ok && (spawn_slot === v.es) && (spawn_lane === v.el);
        check($sformatf("row%0d", k), ok,
              $sformatf("got v=%0b s=%0d l=%0d busy=%b cnt=%0d, want v=%0b s=%0d l=%0d busy=%b cnt=%0d",
                        spawn_valid, spawn_slot, spawn_lane, slot_busy, obj_count,
                        v.ev, v.es, v.el, v.eb, v.ec));
    endtask

    initial begin
        logic stall_ok;
        logic hold_ok;

        // lvl   rdy  n   died  done     ftk  chk  ev  es  el  busy     cnt
        add(3'b001, 0,  0, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0);  // 0  IDLE->COUNT
        add(3'b001, 0, 59, 0, 4'b0000, 1, 0, 0, 0, 0, 4'b0000, 0);  // 1  60th tick -> ALLOC
        add(3'b001, 0,  0, 0, 4'b0000, 0, 1, 1, 0, 5, 4'b0000, 0);  // 2  slot0 lane5
        add(3'b001, 1,  0, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0001, 1);  // 3  handshake
        add(3'b001, 1, 59, 0, 4'b0000, 1, 0, 0, 0, 0, 4'b0001, 1);  // 4
        add(3'b001, 1,  0, 0, 4'b0000, 0, 1, 1, 1, 2, 4'b0001, 1);  // 5  slot1 lane2
        add(3'b001, 1,  0, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0011, 2);  // 6
        add(3'b001, 0, 59, 0, 4'b0000, 1, 0, 0, 0, 0, 4'b0011, 2);  // 7
        add(3'b001, 0,  0, 0, 4'b0000, 0, 1, 1, 2, 5, 4'b0011, 2);  // 8  slot2 lane5
        add(3'b001, 0, 30, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0111, 3);  // 9  cnt = 30
        add(3'b010, 0,  0, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0111, 3);  // 10 L0->L1 clears cnt
        add(3'b010, 0, 39, 0, 4'b0000, 1, 0, 0, 0, 0, 4'b0111, 3);  // 11 40th tick
        add(3'b010, 0,  0, 0, 4'b0000, 0, 1, 1, 3, 2, 4'b0111, 3);  // 12 slot3 lane2
        add(3'b100, 0,  0, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0111, 3);  // 13 L1->L2 drops request
        add(3'b100, 0, 24, 0, 4'b0000, 1, 0, 0, 0, 0, 4'b0111, 3);  // 14
        add(3'b100, 0,  0, 0, 4'b0000, 0, 1, 1, 3, 2, 4'b0111, 3);  // 15 lfsr not stepped by drop
        add(3'b100, 1,  0, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b1111, 4);  // 16
        add(3'b100, 1, 24, 0, 4'b0000, 1, 0, 0, 0, 0, 4'b1111, 4);  // 17 ALLOC, none free
        add(3'b100, 1,  0, 0, 4'b0100, 0, 0, 0, 0, 0, 4'b1011, 4);  // 18 free slot2
        add(3'b100, 1,  0, 0, 4'b0000, 0, 1, 1, 2, 4, 4'b1011, 4);  // 19 slot2 lane4
        add(3'b100, 1,  0, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b1111, 5);  // 20
        add(3'b100, 0,  0, 0, 4'b1000, 0, 0, 0, 0, 0, 4'b0111, 5);  // 21
        add(3'b100, 0, 24, 0, 4'b0000, 1, 0, 0, 0, 0, 4'b0111, 5);  // 22
        add(3'b100, 0,  0, 0, 4'b0000, 0, 1, 1, 3, 1, 4'b0111, 5);  // 23 slot3 lane1
        add(3'b100, 0,  0, 1, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0);  // 24 flush mid-ISSUE
        add(3'b100, 0,  0, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 0);  // 25 IDLE->COUNT
        add(3'b100, 0, 24, 0, 4'b0000, 1, 0, 0, 0, 0, 4'b0000, 0);  // 26
        add(3'b100, 0,  0, 0, 4'b0000, 0, 1, 1, 0, 1, 4'b0000, 0);  // 27 lfsr kept over flush
        add(3'b100, 1,  0, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0001, 1);  // 28
        add(3'b100, 0, 24, 0, 4'b0000, 1, 0, 0, 0, 0, 4'b0001, 1);  // 29
        add(3'b100, 0,  0, 0, 4'b0000, 0, 1, 1, 1, 3, 4'b0001, 1);  // 30 slot1 lane3
        add(3'b100, 1,  0, 0, 4'b0001, 0, 0, 0, 0, 0, 4'b0010, 2);  // 31 done[0] + hs slot1
        add(3'b000, 0,  0, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0010, 2);  // 32 no play keeps busy
        add(3'b011, 0, 30, 0, 4'b0000, 1, 0, 0, 0, 0, 4'b0010, 2);  // 33 invalid level = idle
        add(3'b001, 0,  0, 0, 4'b0000, 0, 0, 0, 0, 0, 4'b0010, 2);  // 34
        add(3'b001, 0, 59, 0, 4'b0000, 1, 0, 0, 0, 0, 4'b0010, 2);  // 35
        add(3'b001, 0,  0, 0, 4'b0000, 0, 1, 1, 0, 7, 4'b0010, 2);  // 36 slot0 lane7

        reset       = 1'b1;
        frame_tick  = 1'b0;
        level       = 3'b000;
        playerDied  = 1'b0;
        slot_done   = 4'b0000;
        spawn_ready = 1'b0;
        step();
        step();
        check("reset", (spawn_valid === 1'b0) && (spawn_slot === 2'd0) && (spawn_lane === 3'd0)
                       && (slot_busy === 4'b0000) && (obj_count === 11'd0),
              $sformatf("got v=%0b s=%0d l=%0d busy=%b cnt=%0d, want all zero",
                        spawn_valid, spawn_slot, spawn_lane, slot_busy, obj_count));
        reset = 1'b0;

        for (int k = 0; k <= 8; k++) apply(k);

        // Backpressure: request must hold steady while the renderer stalls.
        hold_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (!(spawn_valid === 1'b1 && spawn_slot === 2'd2 && spawn_lane === 3'd5)) hold_ok = 1'b0;
        end
        check("hold_stable", hold_ok,
              $sformatf("got v=%0b s=%0d l=%0d, want v=1 s=2 l=5", spawn_valid, spawn_slot, spawn_lane));
        spawn_ready = 1'b1;
        step();
        check("hold_accept", (spawn_valid === 1'b0) && (obj_count === 11'd3) && (slot_busy === 4'b0111),
              $sformatf("got v=%0b cnt=%0d busy=%b, want v=0 cnt=3 busy=0111",
                        spawn_valid, obj_count, slot_busy));
        spawn_ready = 1'b0;
        step();
        check("hold_single_inc", obj_count === 11'd3,
              $sformatf("got cnt=%0d, want 3", obj_count));

        for (int k = 9; k <= 17; k++) apply(k);

        // All slots busy: the spawn waits in ALLOC across many ticks.
        stall_ok = 1'b1;
        for (int t = 0; t < 200; t++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            if (spawn_valid !== 1'b0) stall_ok = 1'b0;
            repeat (3) begin
                step();
                if (spawn_valid !== 1'b0) stall_ok = 1'b0;
            end
        end
        check("stall_no_valid", stall_ok && (slot_busy === 4'b1111),
              $sformatf("got v=%0b busy=%b, want valid low throughout, busy=1111",
                        spawn_valid, slot_busy));

        for (int k = 18; k < tbl.size(); k++) apply(k);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
